// File: rtl/g_sensor_pkg.sv
// Shared constants, register map and FSM state type for the g-sensor SPI responder.
package g_sensor_pkg;

  localparam logic [7:0] DEVID_DEFAULT   = 8'hE5;
  localparam int         CMD_RW_BIT      = 7;
  localparam int         CMD_MB_BIT      = 6;

  localparam logic [5:0] ADDR_DEVID      = 6'h00;
  localparam logic [5:0] ADDR_RAM_LO     = 6'h1E;
  localparam logic [5:0] ADDR_RAM_HI     = 6'h31;
  localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
  localparam logic [5:0] ADDR_DATA_LO    = 6'h32;
  localparam logic [5:0] ADDR_DATA_HI    = 6'h37;

  localparam int RAM_DEPTH  = 20;
  localparam int INT_EN_IDX = 16;  // 0x2E - 0x1E

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD,
    ST_WR
  } spi_state_t;

  function automatic logic is_ram_addr(input logic [5:0] a);
    return (a >= ADDR_RAM_LO) && (a <= ADDR_RAM_HI);
  endfunction

  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATA_LO) && (a <= ADDR_DATA_HI);
  endfunction

endpackage

// File: rtl/g_sensor_spi_responder_if.sv
// SPI pin bundle between the accelerometer controller (master) and the responder (slave).
interface g_sensor_spi_responder_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_sdi;
  logic spi_sdo;
  logic spi_sdo_oe;

  modport master (output spi_sclk, output spi_cs_n, output spi_sdi,
                  input  spi_sdo,  input  spi_sdo_oe);
  modport slave  (input  spi_sclk, input  spi_cs_n, input  spi_sdi,
                  output spi_sdo,  output spi_sdo_oe);
endinterface

// File: rtl/g_sensor_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin with rise/fall detection.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/g_sensor_spi_responder.sv
// SPI mode-3 register responder for an accelerometer: ID, scratch RAM, coherent sample readout, DATA_READY.
//   state   | meaning
//   ST_IDLE | chip select high; sample shadow may copy into data registers
//   ST_CMD  | shifting in the command byte
//   ST_RD   | shifting out register bytes on spi_sdo
//   ST_WR   | shifting in data bytes, committing each after its 8th bit
module g_sensor_spi_responder
  import g_sensor_pkg::*;
#(
  parameter logic [7:0] DEVID       = DEVID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  g_sensor_spi_responder_if.slave   spi,
  input  logic [15:0]               accel_x,
  input  logic [15:0]               accel_y,
  input  logic [15:0]               accel_z,
  input  logic                      accel_valid,
  output logic                      int1
);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic sdi_level, sdi_rise_unused, sdi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(CLOCK_50), .rst(reset), .din(spi.spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

  // cs_n resets as "asserted" so a select held low across reset never looks like a fresh fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk(CLOCK_50), .rst(reset), .din(spi.spi_cs_n),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(CLOCK_50), .rst(reset), .din(spi.spi_sdi),
    .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

  spi_state_t  state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  shift_out;
  logic [5:0]  addr;
  logic        mb;
  logic        rd_hit;
  logic [7:0]  ram [0:RAM_DEPTH-1];
  logic [15:0] shadow_x, shadow_y, shadow_z;
  logic [15:0] data_x, data_y, data_z;
  logic        pending;

  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic [4:0]  ram_off;

  assign rx_byte = {shift_in, sdi_level};
  assign ram_off = 5'(addr - ADDR_RAM_LO);

  always_comb begin
    rd_byte = 8'h00;
    if (addr == ADDR_DEVID) begin
      rd_byte = DEVID;
    end else if (is_ram_addr(addr)) begin
      rd_byte = ram[ram_off];
    end else begin
      case (addr)
        6'h32:   rd_byte = data_x[7:0];
        6'h33:   rd_byte = data_x[15:8];
        6'h34:   rd_byte = data_y[7:0];
        6'h35:   rd_byte = data_y[15:8];
        6'h36:   rd_byte = data_z[7:0];
        6'h37:   rd_byte = data_z[15:8];
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      shift_in       <= '0;
      shift_out      <= '0;
      addr           <= '0;
      mb             <= 1'b0;
      rd_hit         <= 1'b0;
      spi.spi_sdo    <= 1'b0;
      spi.spi_sdo_oe <= 1'b0;
      int1           <= 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
      shadow_x       <= '0;
      shadow_y       <= '0;
      shadow_z       <= '0;
      data_x         <= '0;
      data_y         <= '0;
      data_z         <= '0;
      pending        <= 1'b0;
    end else begin
      if (accel_valid) begin
        shadow_x <= accel_x;
        shadow_y <= accel_y;
        shadow_z <= accel_z;
        pending  <= 1'b1;
      end

      if (cs_rise) begin
        state          <= ST_IDLE;
        spi.spi_sdo    <= 1'b0;
        spi.spi_sdo_oe <= 1'b0;
        rd_hit         <= 1'b0;
        if (rd_hit) int1 <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= rx_byte[6:0];
              if (bit_cnt == 3'd7) begin
                addr  <= rx_byte[5:0];
                mb    <= rx_byte[CMD_MB_BIT];
                state <= rx_byte[CMD_RW_BIT] ? ST_RD : ST_WR;
              end
            end
          end
          ST_RD: begin
            if (sclk_fall) begin
              spi.spi_sdo_oe <= 1'b1;
              if (bit_cnt == 3'd0) begin
                spi.spi_sdo <= rd_byte[7];
                shift_out   <= {rd_byte[6:0], 1'b0};
                if (is_data_addr(addr)) rd_hit <= 1'b1;
              end else begin
                spi.spi_sdo <= shift_out[7];
                shift_out   <= {shift_out[6:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && mb) addr <= addr + 6'd1;
            end
          end
          ST_WR: begin
            if (sclk_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              shift_in <= rx_byte[6:0];
              if (bit_cnt == 3'd7) begin
                if (is_ram_addr(addr)) ram[ram_off] <= rx_byte;
                if (mb) addr <= addr + 6'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Placed after the clear so a coincident set takes priority.
      if (state == ST_IDLE && pending) begin
        data_x  <= shadow_x;
        data_y  <= shadow_y;
        data_z  <= shadow_z;
        pending <= accel_valid;
        if (ram[INT_EN_IDX][7]) int1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_g_sensor_spi_responder.sv
// Directed bench for the g-sensor SPI responder: ID read, samples, coherency, writes, wrap, reset.
module tb_g_sensor_spi_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        accel_valid;
  logic        int1;

  g_sensor_spi_responder_if sif ();

  g_sensor_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .spi        (sif.slave),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_z    (accel_z),
    .accel_valid(accel_valid),
    .int1       (int1)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tx_buf [0:7];
  logic [7:0]  rx_buf [0:7];
  logic        oe_cmd_any, oe_data_all, int1_before_cs;
  logic [15:0] nx, ny, nz;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_accel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    accel_x = x; accel_y = y; accel_z = z; accel_valid = 1'b1;
    wait_clk(1);
    accel_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                           output logic oe_or, output logic oe_and);
    rx = 8'h00; oe_or = 1'b0; oe_and = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      sif.spi_sclk = 1'b0;
      sif.spi_sdi  = tx[7-i];
      wait_clk(HALF);
      rx     = {rx[6:0], sif.spi_sdo};
      oe_or  = oe_or | sif.spi_sdo_oe;
      oe_and = oe_and & sif.spi_sdo_oe;
      sif.spi_sclk = 1'b1;
      wait_clk(HALF);
    end
  endtask

  // Byte 0 is the command; the last byte may be cut short; pulse_after < 0 means no mid-burst sample.
  task automatic spi_txn(input int nbytes, input int last_bits, input int pulse_after);
    logic o_or, o_and;
    sif.spi_cs_n = 1'b0;
    wait_clk(HALF);
    oe_cmd_any = 1'b0; oe_data_all = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      send_bits(tx_buf[b], (b == nbytes - 1) ? last_bits : 8, rx_buf[b], o_or, o_and);
      if (b == 0) oe_cmd_any = o_or;
      else        oe_data_all = oe_data_all & o_and;
      if (b == pulse_after) pulse_accel(nx, ny, nz);
    end
    wait_clk(HALF);
    int1_before_cs = int1;
    sif.spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic read1(input logic [5:0] a, output logic [7:0] v);
    tx_buf[0] = {2'b10, a}; tx_buf[1] = 8'h00;
    spi_txn(2, 8, -1);
    v = rx_buf[1];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sif.spi_cs_n = 1'b1; sif.spi_sclk = 1'b1; sif.spi_sdi = 1'b0;
    accel_x = '0; accel_y = '0; accel_z = '0; accel_valid = 1'b0;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);
    checks++;
    if (sif.spi_sdo_oe !== 1'b0 || sif.spi_sdo !== 1'b0 || int1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: oe=%b sdo=%b int1=%b required 0 0 0", sif.spi_sdo_oe, sif.spi_sdo, int1);
    end
  endtask

  task automatic test_devid;
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_txn(3, 8, -1);
    checks++;
    if (rx_buf[1] !== 8'hE5) begin failures++; $display("FAIL devid_byte0: got %h required e5", rx_buf[1]); end
    checks++;
    if (rx_buf[2] !== 8'hE5) begin failures++; $display("FAIL devid_fixed_addr: got %h required e5", rx_buf[2]); end
    checks++;
    if (oe_cmd_any !== 1'b0) begin failures++; $display("FAIL oe_during_cmd: got %b required 0", oe_cmd_any); end
    checks++;
    if (oe_data_all !== 1'b1) begin failures++; $display("FAIL oe_during_data: got %b required 1", oe_data_all); end
    checks++;
    if (sif.spi_sdo_oe !== 1'b0) begin failures++; $display("FAIL oe_after_cs: got %b required 0", sif.spi_sdo_oe); end
  endtask

  task automatic test_sample_burst;
    logic [7:0] exp [0:5];
    logic [7:0] v;
    exp = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
    tx_buf[0] = 8'h2E; tx_buf[1] = 8'h80;
    spi_txn(2, 8, -1);
    read1(6'h2E, v);
    checks++;
    if (v !== 8'h80) begin failures++; $display("FAIL int_enable_rb: got %h required 80", v); end
    pulse_accel(16'h1234, 16'hFF80, 16'h0100);
    wait_clk(4);
    checks++;
    if (int1 !== 1'b1) begin failures++; $display("FAIL int1_set: got %b required 1", int1); end
    tx_buf[0] = 8'hF2;
    for (int i = 1; i <= 6; i++) tx_buf[i] = 8'h00;
    spi_txn(7, 8, -1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx_buf[i+1] !== exp[i]) begin
        failures++; $display("FAIL burst_byte%0d: got %h required %h", i, rx_buf[i+1], exp[i]);
      end
    end
    checks++;
    if (int1_before_cs !== 1'b1) begin failures++; $display("FAIL int1_held_in_burst: got %b required 1", int1_before_cs); end
    checks++;
    if (int1 !== 1'b0) begin failures++; $display("FAIL int1_clear: got %b required 0", int1); end
  endtask

  task automatic test_coherent;
    logic [7:0] old_exp [0:5];
    logic [7:0] new_exp [0:5];
    old_exp = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
    new_exp = '{8'hCD, 8'hAB, 8'h01, 8'h00, 8'h00, 8'h80};
    nx = 16'hABCD; ny = 16'h0001; nz = 16'h8000;
    tx_buf[0] = 8'hF2;
    for (int i = 1; i <= 6; i++) tx_buf[i] = 8'h00;
    spi_txn(7, 8, 2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx_buf[i+1] !== old_exp[i]) begin
        failures++; $display("FAIL coherent_old%0d: got %h required %h", i, rx_buf[i+1], old_exp[i]);
      end
    end
    checks++;
    if (int1_before_cs !== 1'b0) begin failures++; $display("FAIL int1_pending_mid: got %b required 0", int1_before_cs); end
    checks++;
    if (int1 !== 1'b1) begin failures++; $display("FAIL int1_reassert: got %b required 1", int1); end
    spi_txn(7, 8, -1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx_buf[i+1] !== new_exp[i]) begin
        failures++; $display("FAIL coherent_new%0d: got %h required %h", i, rx_buf[i+1], new_exp[i]);
      end
    end
    checks++;
    if (int1 !== 1'b0) begin failures++; $display("FAIL int1_clear2: got %b required 0", int1); end
  endtask

  task automatic test_readonly_write;
    logic [7:0] v;
    tx_buf[0] = 8'h71; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
    spi_txn(3, 8, -1);
    read1(6'h31, v);
    checks++;
    if (v !== 8'hAA) begin failures++; $display("FAIL ram_0x31: got %h required aa", v); end
    read1(6'h32, v);
    checks++;
    if (v !== 8'hCD) begin failures++; $display("FAIL ro_0x32: got %h required cd", v); end
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h5A;
    spi_txn(2, 8, -1);
    read1(6'h00, v);
    checks++;
    if (v !== 8'hE5) begin failures++; $display("FAIL ro_devid: got %h required e5", v); end
  endtask

  task automatic test_partial_write;
    logic [7:0] v;
    tx_buf[0] = 8'h1E; tx_buf[1] = 8'hFF;
    spi_txn(2, 5, -1);
    read1(6'h1E, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL partial_write: got %h required 00", v); end
  endtask

  task automatic test_wrap;
    tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_txn(3, 8, -1);
    checks++;
    if (rx_buf[1] !== 8'h00) begin failures++; $display("FAIL wrap_0x3f: got %h required 00", rx_buf[1]); end
    checks++;
    if (rx_buf[2] !== 8'hE5) begin failures++; $display("FAIL wrap_0x00: got %h required e5", rx_buf[2]); end
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] rx;
    logic       o_or, o_and;
    logic [7:0] v;
    sif.spi_cs_n = 1'b0;
    wait_clk(HALF);
    send_bits(8'h80, 8, rx, o_or, o_and);
    send_bits(8'h00, 3, rx, o_or, o_and);
    checks++;
    if (o_and !== 1'b1) begin failures++; $display("FAIL oe_before_reset: got %b required 1", o_and); end
    reset = 1'b1;
    #1;
    checks++;
    if (sif.spi_sdo_oe !== 1'b0 || sif.spi_sdo !== 1'b0) begin
      failures++; $display("FAIL reset_async_oe: oe=%b sdo=%b required 0 0", sif.spi_sdo_oe, sif.spi_sdo);
    end
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    send_bits(8'h80, 8, rx, o_or, o_and);
    send_bits(8'h00, 8, rx, o_or, o_and);
    checks++;
    if (o_or !== 1'b0) begin failures++; $display("FAIL no_fresh_fall: oe got %b required 0", o_or); end
    sif.spi_cs_n = 1'b1;
    wait_clk(8);
    read1(6'h00, v);
    checks++;
    if (v !== 8'hE5) begin failures++; $display("FAIL recover_devid: got %h required e5", v); end
    read1(6'h32, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL reset_data: got %h required 00", v); end
    read1(6'h31, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL reset_ram: got %h required 00", v); end
    checks++;
    if (int1 !== 1'b0) begin failures++; $display("FAIL reset_int1: got %b required 0", int1); end
  endtask

  initial begin
    test_reset();
    test_devid();
    test_sample_burst();
    test_coherent();
    test_readonly_write();
    test_partial_write();
    test_wrap();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/g_sensor_spi_responder.md
G_SENSOR_SPI_RESPONDER -- requirements
Module: g_sensor_spi_responder

Interface
REQ-001 SHALL have parameter DEVID, 8'hE5: value returned at register 0x00.
REQ-002 SHALL have parameter SYNC_STAGES, 2: synchronizer depth on SPI inputs (range 2..3).
REQ-003 SHALL have port CLOCK_50  in  1: sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port spi_sclk  in  1: SPI clock from the accelerometer controller, mode 3 (idles high).
REQ-006 SHALL have port spi_cs_n  in  1: active-low chip select.
REQ-007 SHALL have port spi_sdi  in  1: serial data in, MSB first.
REQ-008 SHALL have port spi_sdo  out  1: serial data out, MSB first.
REQ-009 SHALL have port spi_sdo_oe  out  1: high while driving spi_sdo; supports 3-wire tri-state at top level.
REQ-010 SHALL have ports accel_x, accel_y, accel_z  in  16 each: signed sample words.
REQ-011 SHALL have port accel_valid  in  1: one-cycle strobe marking a new sample.
REQ-012 SHALL have port int1  out  1: DATA_READY interrupt, active-high.

Function
REQ-013 SHALL pass spi_sclk, spi_cs_n and spi_sdi through SYNC_STAGES flops, then detect edges; the SPI master SHALL hold each SCLK half-period for at least 4 CLOCK_50 cycles.
REQ-014 SHALL sample spi_sdi on a synchronized SCLK rising edge and update spi_sdo on a synchronized SCLK falling edge.
REQ-015 SHALL implement FSM IDLE -> CMD on a spi_cs_n falling edge; CMD -> RD or WR after 8 bits; RD/WR loop per byte; any state -> IDLE on a spi_cs_n rising edge.
REQ-016 SHALL decode command byte as bit7 = R/W (1 = read), bit6 = MB (multi-byte), bits5:0 = start address.
REQ-017 SHALL auto-increment the address after each data byte when MB = 1, wrapping 0x3F -> 0x00; with MB = 0 the address SHALL stay fixed.
REQ-018 SHALL, in RD, drive spi_sdo_oe = 1 and shift out the register byte, loading the first bit on the first SCLK falling edge after the command byte.
REQ-019 SHALL, in WR, commit a byte only after its 8th bit; a partial byte cut off by spi_cs_n rising SHALL be discarded.
REQ-020 SHALL provide the register map: 0x00 = DEVID (read-only); 0x1E..0x31 = writable RAM, reset 0x00; 0x32..0x37 = X0,X1,Y0,Y1,Z0,Z1 (low byte first, read-only); all others read 0x00 and ignore writes.
REQ-021 SHALL latch accel_x/y/z into a shadow set on accel_valid; the shadow SHALL copy into data registers 0x32..0x37 only while in IDLE, so a burst read is coherent.
REQ-022 SHALL, if accel_valid arrives while not IDLE, hold it pending and apply it on the cycle after the return to IDLE; a newer accel_valid SHALL overwrite the pending sample.
REQ-023 SHALL set int1 when data registers update and bit7 of register 0x2E (INT_ENABLE) = 1.
REQ-024 SHALL clear int1 on return to IDLE after any read that covered an address in 0x32..0x37; if set and clear coincide, set SHALL win.
REQ-025 SHALL keep spi_sdo_oe = 0 and spi_sdo = 0 outside RD.

Reset
REQ-026 SHALL, on reset, force state IDLE, spi_sdo = 0, spi_sdo_oe = 0, int1 = 0, writable RAM, shadow and data registers = 0x00, and pending flag = 0.
REQ-027 SHALL, if reset asserts mid-transaction, abort the transaction, commit nothing, and wait for a fresh spi_cs_n falling edge.

Structure
REQ-028 SHALL place register addresses, DEVID default, the R/W and MB bit positions, and the FSM state enum in shared package g_sensor_pkg.
REQ-029 SHALL use one sub-module, spi_sync_edge: synchronizer plus rise/fall detector, instantiated for each SPI input.

Verification
REQ-030 Bench: read 0x80 (single, address 0x00) -> spi_sdo returns 0xE5 and spi_sdo_oe is high only during the data byte.
REQ-031 Bench: write 0x2E = 0x80, then accel_valid with x = 0x1234, y = 0xFF80, z = 0x0100 -> int1 = 1; burst read 0xF2 for 6 bytes -> 34 12 80 FF 00 01; int1 = 0 after CS_N rises.
REQ-032 Bench: accel_valid mid-burst with new values -> the burst returns the old sample; the new sample appears after CS_N rises; int1 re-asserts.
REQ-033 Bench: write 0x40|0x31 burst 0xAA, 0xBB -> 0x31 = 0xAA, 0x32 stays unchanged (read-only).
REQ-034 Bench: CS_N rises after 5 data bits of a write to 0x1E -> 0x1E stays 0x00; reset asserted mid-read -> spi_sdo_oe = 0 immediately.
REQ-035 Bench: MB burst read starting at 0x3F -> the second byte comes from 0x00 (0xE5).
